// File: rtl/sar_controller.sv
// Successive-approximation ADC controller: samples, then binary-searches the DAC code one bit
// per SETTLE/DECIDE round, and holds the result until the consumer handshakes.
module sar_controller #(
    parameter int unsigned N_BITS        = 11,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              comp_in,
    input  logic              result_ready,
    output logic [N_BITS-1:0] dac_code,
    output logic              sample_hold,
    output logic              busy,
    output logic              result_valid,
    output logic [N_BITS-1:0] result
);

    localparam int unsigned IdxW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [N_BITS-1:0] MsbCode = N_BITS'(1) << (N_BITS - 1);
    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSample, StSettle, StDecide, StDone} state_e;

    state_e            state;
    logic [IdxW-1:0]   bit_idx;
    logic [3:0]        settle_cnt;
    logic [1:0]        rst_sync;
    logic [N_BITS-1:0] decided;
    logic [N_BITS-1:0] next_trial;

    // Reset asserts asynchronously but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    always_comb begin
        decided          = dac_code;
        decided[bit_idx] = comp_in;
        next_trial       = decided;
        if (bit_idx != '0) begin
            next_trial[bit_idx - IdxW'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            bit_idx      <= '0;
            settle_cnt   <= '0;
            dac_code     <= '0;
            result       <= '0;
            sample_hold  <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else if (rst_sync[1]) begin
            // busy is high exactly in SAMPLE, SETTLE and DECIDE, so it qualifies abort.
            if (abort && busy) begin
                state       <= StIdle;
                dac_code    <= '0;
                sample_hold <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (start) begin
                            state       <= StSample;
                            dac_code    <= '0;
                            sample_hold <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                    StSample: begin
                        state       <= StSettle;
                        sample_hold <= 1'b0;
                        bit_idx     <= IdxW'(N_BITS - 1);
                        dac_code    <= MsbCode;
                        settle_cnt  <= SettleLoad;
                    end
                    StSettle: begin
                        if (settle_cnt == '0) begin
                            state <= StDecide;
                        end else begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end
                    end
                    StDecide: begin
                        if (bit_idx == '0) begin
                            state        <= StDone;
                            result       <= decided;
                            dac_code     <= decided;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                        end else begin
                            state      <= StSettle;
                            dac_code   <= next_trial;
                            bit_idx    <= bit_idx - IdxW'(1);
                            settle_cnt <= SettleLoad;
                        end
                    end
                    StDone: begin
                        if (result_ready) begin
                            result_valid <= 1'b0;
                            dac_code     <= '0;
                            if (start) begin
                                state       <= StSample;
                                sample_hold <= 1'b1;
                                busy        <= 1'b1;
                            end else begin
                                state <= StIdle;
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sar_controller.sv
// Bench for sar_controller: table-driven and random conversions against a binary-search model,
// plus hand-written sequences for stall, abort, reset and back-to-back handshakes.
module tb_sar_controller;

    localparam int N    = 11;
    localparam int S    = 2;
    localparam int CONV = 1 + N * (S + 1);

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         result_ready = 1'b0;
    logic         comp_in;
    logic [N-1:0] dac_code;
    logic         sample_hold;
    logic         busy;
    logic         result_valid;
    logic [N-1:0] result;

    int analog = 0;
    int comp_mode = 0;  // 0: compare analog, 1: always 1, 2: always 0
    int vectors = 0;
    int miscompares = 0;
    int last_result = 0;
    int exp_trial[N];
    int exp_result = 0;

    typedef struct {
        int analog;
        int mode;
        int want;
    } vec_t;
    vec_t tbl[8];

    assign comp_in = (comp_mode == 1) ? 1'b1 :
                     (comp_mode == 2) ? 1'b0 : (analog >= int'(dac_code));

    sar_controller #(.N_BITS(N), .SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .comp_in      (comp_in),
        .result_ready (result_ready),
        .dac_code     (dac_code),
        .sample_hold  (sample_hold),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ideal binary search: try each bit from MSB down, keep it if the input is at or above it.
    task automatic model(input int a, input int mode);
        int code = 0;
        for (int b = N - 1; b >= 0; b--) begin
            int trial = code | (1 << b);
            exp_trial[N - 1 - b] = trial;
            if (mode == 1 || (mode == 0 && a >= trial)) code = trial;
        end
        exp_result = code;
    endtask

    // Leaves the DUT in DONE with result_ready low.
    task automatic convert(input int a, input int mode, input int want, input bit sampling,
                           input bit noisy);
        analog    = a;
        comp_mode = mode;
        model(a, mode);
        result_ready = 1'b0;
        if (!sampling) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("sample_state", {sample_hold, busy, result_valid}, 3'b110);
        check("sample_dac", dac_code, 0);
        for (int e = 1; e < CONV; e++) begin
            start = noisy ? 1'($urandom % 2) : 1'b0;
            tick();
            check("trial_dac", dac_code, exp_trial[(e - 1) / (S + 1)]);
            check("busy_state", {sample_hold, busy, result_valid}, 3'b010);
        end
        start = 1'b0;
        tick();
        check("done_valid", {sample_hold, busy, result_valid}, 3'b001);
        check("done_result", result, want);
        check("done_dac", dac_code, want);
        last_result = want;
    endtask

    task automatic handshake(input bit with_start);
        result_ready = 1'b1;
        start        = with_start;
        tick();
        result_ready = 1'b0;
        start        = 1'b0;
        check("hs_valid_drop", result_valid, 0);
        check("hs_result_kept", result, last_result);
        check("hs_dac", dac_code, 0);
        check("hs_state", {sample_hold, busy}, with_start ? 2'b11 : 2'b00);
    endtask

    initial begin
        tbl[0] = '{1234, 0, 1234};
        tbl[1] = '{0,    1, 2047};
        tbl[2] = '{0,    2, 0};
        tbl[3] = '{700,  0, 700};
        tbl[4] = '{1,    0, 1};
        tbl[5] = '{3000, 0, 2047};
        tbl[6] = '{2047, 0, 2047};
        tbl[7] = '{1023, 0, 1023};

        // Reset state and synchronized release.
        #2;
        check("reset_outputs", {dac_code, sample_hold, busy, result_valid, result}, 0);
        tick();
        tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        check("release_edge1", busy, 0);
        tick();
        check("release_edge2", busy, 0);
        start = 1'b0;
        tick();
        check("release_idle", {busy, sample_hold, result_valid, dac_code}, 0);

        for (int i = 0; i < 8; i++) begin
            convert(tbl[i].analog, tbl[i].mode, tbl[i].want, 1'b0, 1'b0);
            handshake(1'b0);
        end

        for (int i = 0; i < 15; i++) begin
            int a = int'($urandom_range(0, 2500));
            model(a, 0);
            convert(a, 0, exp_result, 1'b0, 1'b1);
            handshake(1'b0);
        end

        // Stalled consumer while start toggles: DONE must hold.
        convert(901, 0, 901, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            start = 1'(i % 2);
            tick();
            check("stall_state", {sample_hold, busy, result_valid}, 3'b001);
            check("stall_result", result, 901);
            check("stall_dac", dac_code, 901);
        end
        start = 1'b0;
        handshake(1'b0);

        // Abort during the third DECIDE (cycle after edge 9 from start).
        analog    = 500;
        comp_mode = 0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        check("pre_abort_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", {sample_hold, busy, result_valid}, 3'b000);
        check("abort_dac", dac_code, 0);
        check("abort_result", result, last_result);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_valid", {busy, result_valid}, 2'b00);
        end

        // Reset mid-SETTLE.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("async_reset", {dac_code, sample_hold, busy, result_valid, result}, 0);
        tick();
        reset = 1'b1;
        last_result = 0;
        for (int i = 0; i < 4; i++) tick();
        check("post_reset_idle", {busy, result_valid, dac_code}, 0);
        convert(700, 0, 700, 1'b0, 1'b0);

        // Handshake with start in the same cycle: straight into SAMPLE for one cycle.
        handshake(1'b1);
        convert(333, 0, 333, 1'b1, 1'b0);
        handshake(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
